mj32_mem_ctrl: RTL and testbench

Parametrised multi-channel memory controller for the MJ32 platform. It replaces the separate instruction and data memories with one unified word-addressed RAM. NUM_CH requesters (channel 0 = instruction fetch, channel 1 = data load/store, extra channels for future DMA/debug) share the RAM through round-robin arbitration, a req/ack handshake, a configurable wait-state count, byte-enabled writes and out-of-range error reporting.

---
 rtl/mj32_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_mj32_mem_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mj32_mem_ctrl.sv
// mj32_mem_ctrl: unified word-addressed RAM shared by NUM_CH round-robin requesters
module mj32_mem_ctrl #(
   parameter int    NUM_CH      = 2,
   parameter int    ADDR_W      = 32,
   parameter int    DATA_W      = 32,
   parameter int    DEPTH_WORDS = 256,
   parameter int    WAIT_STATES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH-1:0]          we,
   input  logic [NUM_CH*ADDR_W-1:0]   addr,
   input  logic [NUM_CH*DATA_W-1:0]   wdata,
   input  logic [NUM_CH*DATA_W/8-1:0] be,
   output logic [NUM_CH-1:0]          ack,
   output logic [NUM_CH-1:0]          err,
   output logic [DATA_W-1:0]          rdata,
   output logic                       busy
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int WI_W  = ADDR_W - OFF_W;
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int PTR_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d, g_q, g_d, pick;
   logic              we_q, we_d, found, in_rng, access;
   logic [WI_W-1:0]   widx_q, widx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [NUM_CH-1:0] ack_q, ack_d, err_q, err_d;
   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (!found && req[(int'(ptr_q) + k) % NUM_CH]) begin
            found = 1'b1;
            pick  = PTR_W'((int'(ptr_q) + k) % NUM_CH);
         end
   end

   assign in_rng = (widx_q >> IDX_W) == '0;
   assign access = state_q == BUSY && cnt_q == 4'd0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      we_d    = we_q;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      ack_d   = ack_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (found) begin
            state_d = BUSY;
            g_d     = pick;
            we_d    = we[pick];
            widx_d  = addr[int'(pick)*ADDR_W + OFF_W +: WI_W];
            wdata_d = wdata[int'(pick)*DATA_W +: DATA_W];
            be_d    = be[int'(pick)*BE_W +: BE_W];
            cnt_d   = 4'(WAIT_STATES);
            ptr_d   = int'(pick) == NUM_CH - 1 ? '0 : pick + 1'b1;
         end
         BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         else begin
            state_d = RESP;
            ack_d   = NUM_CH'(1) << g_q;
            err_d   = in_rng ? '0 : NUM_CH'(1) << g_q;
            rdata_d = (!we_q && in_rng) ? mem[widx_q[IDX_W-1:0]] : '0;
         end
         RESP: begin
            state_d = IDLE;
            ack_d   = '0;
            err_d   = '0;
            rdata_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         g_q     <= '0;
         we_q    <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         we_q    <= we_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end

   always_ff @(posedge clk)
      if (access && we_q && in_rng)
         for (int b = 0; b < BE_W; b++)
            if (be_q[b]) mem[widx_q[IDX_W-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];

   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_mj32_mem_ctrl.sv
// tb_mj32_mem_ctrl: scoreboard bench for the main 2-channel controller (WAIT_STATES=1)
// plus directed latency/abort checks on WAIT_STATES=0 and 3 instances.
module tb_mj32_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, we, ack, err;
   logic [63:0] addr, wdata;
   logic [7:0]  be;
   logic [31:0] rdata;
   logic        busy;
   logic [1:0]  req0, req3, we_x, ack0, ack3, err0, err3;
   logic [63:0] addr_x, wdata_x;
   logic [7:0]  be_x;
   logic [31:0] rdata0, rdata3;
   logic        busy0, busy3;
   int          checks = 0;
   int          errors = 0;

   typedef struct {int ch; logic e_err; logic [31:0] rd;} exp_t;
   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;

   mj32_mem_ctrl #(.WAIT_STATES(1)) dut (
      .clk(clk), .reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .ack(ack), .err(err), .rdata(rdata), .busy(busy));
   mj32_mem_ctrl #(.WAIT_STATES(0)) u_w0 (
      .clk(clk), .reset(rst), .req(req0), .we(we_x), .addr(addr_x), .wdata(wdata_x), .be(be_x),
      .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0));
   mj32_mem_ctrl #(.WAIT_STATES(3)) u_w3 (
      .clk(clk), .reset(rst), .req(req3), .we(we_x), .addr(addr_x), .wdata(wdata_x), .be(be_x),
      .ack(ack3), .err(err3), .rdata(rdata3), .busy(busy3));

   always @(negedge clk)
      if (ack !== 2'b00) begin
         checks++;
         if ($countones(ack) != 1) begin
            errors++;
            $display("FAIL onehot: ack=%b, expected exactly one bit", ack);
         end
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: ack=%b with no pending transaction", ack);
         end else begin
            e = q.pop_front();
            if (ack !== 2'(1 << e.ch) || err !== (e.e_err ? 2'(1 << e.ch) : 2'b00) || rdata !== e.rd) begin
               errors++;
               $display("FAIL sb ch%0d: ack=%b err=%b rdata=%h, expected ack=%b err=%b rdata=%h",
                        e.ch, ack, err, rdata, 2'(1 << e.ch), e.e_err ? 2'(1 << e.ch) : 2'b00, e.rd);
            end
         end
      end

   task automatic m_access(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic e_err, input logic [31:0] e_rd);
      int n = 0;
      q.push_back('{ch, e_err, e_rd});
      we[ch] = w;
      addr[ch*32 +: 32] = a;
      wdata[ch*32 +: 32] = d;
      be[ch*4 +: 4] = b;
      req[ch] = 1'b1;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (!ack[ch] && n < 20);
      checks++;
      if (!ack[ch] || n - 1 != 2) begin
         errors++;
         $display("FAIL m_lat ch%0d addr=%h: latency %0d (ack=%b), expected 2", ch, a, n - 1, ack);
      end
      req[ch] = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic x_access(input bit s3, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int e_lat, input logic [31:0] e_rd);
      int n = 0;
      logic ak, bz;
      we_x = {1'b0, w};
      addr_x = {32'h0, a};
      wdata_x = {32'h0, d};
      be_x = 8'h0F;
      if (s3) req3 = 2'b01; else req0 = 2'b01;
      do begin
         @(posedge clk); n++; @(negedge clk);
         ak = s3 ? ack3[0] : ack0[0];
         bz = s3 ? busy3 : busy0;
         checks++;
         if (!bz) begin
            errors++;
            $display("FAIL x_busy ws%0d cycle %0d: busy=0, expected 1", s3 ? 3 : 0, n);
         end
      end while (!ak && n < 20);
      checks++;
      if (!ak || n - 1 != e_lat) begin
         errors++;
         $display("FAIL x_lat ws%0d addr=%h: latency %0d, expected %0d", s3 ? 3 : 0, a, n - 1, e_lat);
      end
      checks++;
      if ((s3 ? rdata3 : rdata0) !== e_rd || (s3 ? err3 : err0) !== 2'b00) begin
         errors++;
         $display("FAIL x_data ws%0d addr=%h: rdata=%h err=%b, expected rdata=%h err=00",
                  s3 ? 3 : 0, a, s3 ? rdata3 : rdata0, s3 ? err3 : err0, e_rd);
      end
      req0 = 2'b00;
      req3 = 2'b00;
      @(posedge clk); @(negedge clk);
      checks++;
      if ((s3 ? busy3 : busy0) !== 1'b0 || (s3 ? ack3 : ack0) !== 2'b00) begin
         errors++;
         $display("FAIL x_idle ws%0d: busy=%b ack=%b, expected busy=0 ack=00",
                  s3 ? 3 : 0, s3 ? busy3 : busy0, s3 ? ack3 : ack0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, n;
      logic seen;
      rst = 1'b1;
      {req, we, addr, wdata, be} = '0;
      {req0, req3, we_x, addr_x, wdata_x, be_x} = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ack !== 2'b00 || err !== 2'b00 || rdata !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ack=%b err=%b rdata=%h busy=%b, expected all 0", ack, err, rdata, busy);
      end

      m_access(1, 1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0);
      m_access(1, 0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADBEEF);
      m_access(0, 1, 32'h20,  32'h11223344, 4'hF, 0, 32'h0);
      m_access(1, 1, 32'h20,  32'hAABBCCDD, 4'h5, 0, 32'h0);
      m_access(0, 0, 32'h20,  32'h0,        4'hF, 0, 32'h11BB33DD);
      m_access(1, 1, 32'h20,  32'hFFFFFFFF, 4'h0, 0, 32'h0);
      m_access(1, 0, 32'h20,  32'h0,        4'hF, 0, 32'h11BB33DD);
      m_access(0, 1, 32'h0,   32'h55667788, 4'hF, 0, 32'h0);
      m_access(1, 0, 32'h400, 32'h0,        4'hF, 1, 32'h0);
      m_access(1, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
      m_access(0, 0, 32'h0,   32'h0,        4'hF, 0, 32'h55667788);
      m_access(0, 1, 32'h3FC, 32'h0BADCAFE, 4'hF, 0, 32'h0);
      m_access(1, 0, 32'h3FC, 32'h0,        4'hF, 0, 32'h0BADCAFE);
      m_access(0, 0, 32'h13,  32'h0,        4'hF, 0, 32'hDEADBEEF);

      // fresh reset so ch0 has top priority; RAM contents survive it
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         q.push_back('{0, 1'b0, 32'hDEADBEEF});
         q.push_back('{1, 1'b0, 32'h11BB33DD});
      end
      we = 2'b00;
      addr = {32'h20, 32'h10};
      req = 2'b11;
      cnt = 0;
      n = 0;
      while (cnt < 4 && n < 60) begin
         @(posedge clk); n++; @(negedge clk);
         if (ack != 2'b00) cnt++;
      end
      req = 2'b00;
      checks++;
      if (cnt != 4) begin
         errors++;
         $display("FAIL arb_count: %0d acks, expected 4", cnt);
      end
      @(posedge clk); @(negedge clk);

      x_access(0, 1, 32'h0, 32'h01020304, 1, 32'h0);
      x_access(0, 0, 32'h0, 32'h0,        1, 32'h01020304);
      x_access(1, 1, 32'h0, 32'hA5A5C3C3, 4, 32'h0);
      x_access(1, 0, 32'h0, 32'h0,        4, 32'hA5A5C3C3);
      x_access(1, 1, 32'h8, 32'hCAFEF00D, 4, 32'h0);

      we_x = 2'b01;
      addr_x = {32'h0, 32'h8};
      wdata_x = {32'h0, 32'h12345678};
      be_x = 8'h0F;
      req3 = 2'b01;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++;
      if (busy3 !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy: busy=%b, expected 1 before reset", busy3);
      end
      rst = 1'b1;
      req3 = 2'b00;
      #1;
      checks++;
      if (busy3 !== 1'b0) begin
         errors++;
         $display("FAIL abort_async: busy=%b, expected 0 right after reset assert", busy3);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack3 !== 2'b00) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_ack: ack seen after abort, expected none");
      end
      x_access(1, 0, 32'h8, 32'h0, 4, 32'hCAFEF00D);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d pending expectations, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
